// File: rtl/isa_pkg.sv
// Instruction-set constants shared by the fetch stage, decoder and control unit.
package isa_pkg;

    localparam int unsigned INSTR_W = 32;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 27;
    localparam int unsigned ALUOP_MSB  = 26;
    localparam int unsigned ALUOP_LSB  = 24;
    localparam int unsigned RD_MSB     = 23;
    localparam int unsigned RD_LSB     = 20;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS1_LSB    = 16;
    localparam int unsigned RS2_MSB    = 15;
    localparam int unsigned RS2_LSB    = 12;
    localparam int unsigned IMM_MSB    = 11;
    localparam int unsigned IMM_LSB    = 0;

    // ADD r0,r0,r0: no architectural effect, used for bubbles.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [4:0] OP_ALU = 5'b00000;
    localparam logic [4:0] OP_LW  = 5'b00001;
    localparam logic [4:0] OP_SW  = 5'b00010;
    localparam logic [4:0] OP_JMP = 5'b00011;
    localparam logic [4:0] OP_BE  = 5'b00100;
    localparam logic [4:0] OP_VEC = 5'b00101;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  aluop;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [11:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read bus: fetch stage is master, synchronous memory is slave.
interface fetch_unit_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer catching a read that returns while decode is stalled.
module fetch_skid_buf
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               drain_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, 1-cycle synchronous imem reads, stall skid and redirect squash.
module fetch_unit
    import isa_pkg::*;
#(
    parameter int unsigned      ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    fetch_unit_if.master       imem,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               dec_valid,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    output logic [4:0]         OPcode,
    output logic [2:0]         ALUop,
    output logic [3:0]         rd,
    output logic [3:0]         rs1,
    output logic [3:0]         rs2,
    output logic [11:0]        imm
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               ret_valid_q, ret_valid_d;
    logic [ADDR_W-1:0]  ret_pc_q, ret_pc_d;
    logic               dec_valid_q, dec_valid_d;
    logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
    logic [ADDR_W-1:0]  dec_pc_q, dec_pc_d;

    logic               fetch_en;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               skid_load, skid_drain, skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;

    // No fetch while stalled keeps at most one return in flight, so the skid cannot overflow.
    always_comb begin
        fetch_en   = 1'b0;
        fetch_addr = pc_q;
        if (rst) begin
            fetch_en = 1'b0;
        end else if (redirect_valid) begin
            fetch_en   = 1'b1;
            fetch_addr = redirect_target;
        end else if (!stall) begin
            fetch_en = 1'b1;
        end
    end

    assign imem.imem_en   = fetch_en;
    assign imem.imem_addr = fetch_addr;

    assign skid_load  = stall && !redirect_valid && ret_valid_q;
    assign skid_drain = !stall && !redirect_valid && skid_valid;

    always_comb begin
        pc_d        = fetch_en ? fetch_addr + ADDR_W'(4) : pc_q;
        ret_valid_d = fetch_en;
        ret_pc_d    = fetch_en ? fetch_addr : ret_pc_q;
        dec_valid_d = dec_valid_q;
        dec_instr_d = dec_instr_q;
        dec_pc_d    = dec_pc_q;
        if (redirect_valid) begin
            dec_valid_d = 1'b0;
            dec_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (skid_valid) begin
                dec_valid_d = 1'b1;
                dec_instr_d = skid_instr;
                dec_pc_d    = skid_pc;
            end else if (ret_valid_q) begin
                dec_valid_d = 1'b1;
                dec_instr_d = imem.imem_rdata;
                dec_pc_d    = ret_pc_q;
            end else begin
                dec_valid_d = 1'b0;
                dec_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            ret_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            dec_valid_q <= 1'b0;
            dec_instr_q <= NOP_INSTR;
            dec_pc_q    <= '0;
        end else begin
            pc_q        <= pc_d;
            ret_valid_q <= ret_valid_d;
            ret_pc_q    <= ret_pc_d;
            dec_valid_q <= dec_valid_d;
            dec_instr_q <= dec_instr_d;
            dec_pc_q    <= dec_pc_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (redirect_valid),
        .instr_i (imem.imem_rdata),
        .pc_i    (ret_pc_q),
        .valid_o (skid_valid),
        .instr_o (skid_instr),
        .pc_o    (skid_pc)
    );

    assign dec_valid = dec_valid_q;
    assign dec_instr = dec_instr_q;
    assign dec_pc    = dec_pc_q;
    assign OPcode    = dec_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign ALUop     = dec_instr_q[ALUOP_MSB:ALUOP_LSB];
    assign rd        = dec_instr_q[RD_MSB:RD_LSB];
    assign rs1       = dec_instr_q[RS1_MSB:RS1_LSB];
    assign rs2       = dec_instr_q[RS2_MSB:RS2_LSB];
    assign imm       = dec_instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage that feeds OPcode/ALUop and operand fields into the control unit and decode stage.
- It is the producer end of the decoder's opcode interface.
- Keeps the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Absorbs decode stalls through a one-entry skid buffer.
- Applies jump/branch redirects resolved downstream, squashing wrong-path instructions.

Parameters:
- ADDR_W, 32, byte address width of PC and imem_addr.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_en  out  1  read strobe to instruction memory.
- imem_addr  out  ADDR_W  byte address of the read; combinational.
- imem_rdata  in  32  instruction word, valid the cycle after imem_en.
- stall  in  1  decode cannot accept a new instruction; dec_* hold.
- redirect_valid  in  1  taken jump/branch/JR this cycle.
- redirect_target  in  ADDR_W  new fetch address.
- dec_valid  out  1  dec_* holds a real (non-bubble) instruction.
- dec_instr  out  32  registered instruction word.
- dec_pc  out  ADDR_W  address of dec_instr.
- OPcode  out  5  dec_instr[31:27].
- ALUop  out  3  dec_instr[26:24].
- rd  out  4  dec_instr[23:20].
- rs1  out  4  dec_instr[19:16].
- rs2  out  4  dec_instr[15:12].
- imm  out  12  dec_instr[11:0].

Behaviour:
- Internal state:
  - pc_q: next sequential fetch address.
  - ret_valid_q / ret_pc_q: a read is returning this cycle, and its address.
  - skid_valid_q / skid_instr_q / skid_pc_q: one-entry skid buffer.
  - dec_* output register.
- Reset (rst=1 at an edge):
  - pc_q=RESET_PC; ret_valid_q=0; skid_valid_q=0.
  - dec_valid=0; dec_instr=NOP_INSTR (32'h0000_0000 = ADD r0,r0,r0, no architectural effect); dec_pc=0.
  - imem_en=0 while rst=1.
- Fetch address and strobe, per cycle, priority redirect > stall > sequential:
  - redirect_valid=1: imem_en=1, imem_addr=redirect_target.
  - else stall=1 or skid_valid_q=1 with stall=1: imem_en=0.
  - else: imem_en=1, imem_addr=pc_q.
- When a fetch is issued: pc_q<=imem_addr+4 (modulo 2^ADDR_W, wraps to 0); ret_pc_q<=imem_addr; ret_valid_q<=1. Otherwise ret_valid_q<=0.
- Redirect:
  - dec_valid<=0, dec_instr<=NOP_INSTR, skid_valid_q<=0.
  - Returning data this cycle is discarded.
  - The target instruction appears on dec_* 2 edges after the redirect edge, i.e. exactly one bubble.
  - Redirect overrides a simultaneous stall.
- Stall, no redirect:
  - dec_* hold.
  - If ret_valid_q=1, imem_rdata/ret_pc_q go into the skid buffer (skid_valid_q<=1).
  - The skid never overflows: no fetch is issued while stalled, so at most one return lands during a stall.
- No stall, no redirect:
  - If skid_valid_q: dec<=skid contents, dec_valid<=1, skid_valid_q<=0.
  - Else if ret_valid_q: dec<=imem_rdata/ret_pc_q, dec_valid<=1.
  - Else dec_valid<=0 with NOP_INSTR (bubble).
- Stall release with full skid: the skid drains while a new fetch issues the same cycle, so no bubble and no duplicate.
- Latency: rst deasserts before edge E0; the RESET_PC fetch issues in the cycle ending at E0. The instruction is on dec_* after E1, then one instruction per cycle thereafter.
- Field outputs (OPcode, ALUop, rd, rs1, rs2, imm) are pure slices of dec_instr. When dec_valid=0 they decode NOP_INSTR.
- Reset mid-stall or mid-redirect: reset wins; all in-flight and skid contents are dropped.

Decomposition:
- Package isa_pkg:
  - field bit positions: OPCODE_MSB/LSB, ALUOP_MSB/LSB, RD, RS1, RS2, IMM.
  - NOP_INSTR.
  - INSTR_W=32.
  - named opcode constants: OP_ALU=5'b00000, OP_LW, OP_SW, OP_JMP, OP_BE, OP_VEC, ...
  - The control unit and this block share these constants.
- One sub-module: fetch_skid_buf, holding the one-entry buffer: load, drain, flush, valid/instr/pc.

Test Plan:
- Reset then free-run: RESET_PC=0, memory word n = 32'h0000_1000*n → after E1, dec_pc=0,4,8,12 on consecutive edges, dec_valid=1 continuously, dec_instr matches.
- Stall 3 cycles while pc 8 is in dec: dec holds pc 8 for 3 cycles, then 12, 16 follow with no gap or duplicate; imem_en=0 during the last 3 stall cycles.
- Redirect to 0x40 while dec holds 0x10: next edge dec_valid=0 with NOP_INSTR, following edge dec_pc=0x40, then 0x44.
- Redirect to 0x80 in the same cycle as stall with skid full: skid dropped, one bubble, then dec_pc=0x80; imem_addr=0x80 that cycle.
- Field decode: imem word 32'h5012_3ABC at 0x0 → OPcode=5'b01010, ALUop=3'b000, rd=1, rs1=2, rs2=3, imm=12'hABC.
- Wrap: ADDR_W=8, redirect to 8'hFC → dec_pc=0xFC then 0x00.
